// File: rtl/os_array_pkg.sv
// os_array_pkg: shared state encoding, MAC latency and cycle-counter sizing for the OS array controller.
// No ports; imported by os_array_ctrl.
package os_array_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, COMPUTE, DRAIN} state_t;
    localparam int MAC_LAT = 2;
    // Bits needed to hold T_END = k + rows + cols - 2 + mac_lat at the largest k.
    function automatic int t_width(input int kw, input int rows, input int cols, input int mac_lat);
        return $clog2((2 ** kw - 1) + rows + cols - 2 + mac_lat + 1);
    endfunction
endpackage

// File: rtl/os_array_ctrl_if.sv
// os_array_ctrl_if: scheduler, operand-buffer, array and drain signals of the OS array controller.
// master = controller side (drives busy/done/acc_clr/rd_*/masks/drain_*), slave = surrounding logic.
// OS_ARRAY_CTRL_PERF_EN adds the 32-bit stall_cnt output.
interface os_array_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KW   = 10
) ();
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            done;
    logic            acc_clr;
    logic            rd_en;
    logic [KW-1:0]   rd_addr;
    logic [ROWS-1:0] a_live;
    logic [COLS-1:0] b_live;
    logic [RW-1:0]   drain_row;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
`ifdef OS_ARRAY_CTRL_PERF_EN
    logic [31:0]     stall_cnt;
`endif
    modport master (
        input  start, k_len, out_ready,
`ifdef OS_ARRAY_CTRL_PERF_EN
        output stall_cnt,
`endif
        output busy, done, acc_clr, rd_en, rd_addr, a_live, b_live, drain_row, out_valid, out_last
    );
    modport slave (
        output start, k_len, out_ready,
`ifdef OS_ARRAY_CTRL_PERF_EN
        input  stall_cnt,
`endif
        input  busy, done, acc_clr, rd_en, rd_addr, a_live, b_live, drain_row, out_valid, out_last
    );
endinterface

// File: rtl/os_skew_mask.sv
// os_skew_mask: live mask for N skewed operand lanes; lane i is live for t in [i+1, i+1+k).
// Ports: en (only in COMPUTE), t (cycle counter), k (depth), live (N-bit mask).
module os_skew_mask #(
    parameter int N  = 4,
    parameter int KW = 10,
    parameter int TW = 11
) (
    input  logic          en,
    input  logic [TW-1:0] t,
    input  logic [KW-1:0] k,
    output logic [N-1:0]  live
);
    // The +1 absorbs the one-cycle operand buffer read latency.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign live[i] = en && (32'(t) >= 32'(i + 1)) && (32'(t) < 32'(i + 1) + 32'(k));
    end
endmodule

// File: rtl/os_array_ctrl.sv
// os_array_ctrl: per-tile sequencer for an output-stationary systolic array (clear, feed, drain).
// Ports: clk, rst (sync, active high), bus (os_array_ctrl_if.master: start/k_len/busy/done,
// acc_clr, rd_en/rd_addr, a_live/b_live, drain_row/out_valid/out_ready/out_last).
// OS_ARRAY_CTRL_PERF_EN adds bus.stall_cnt counting drain cycles stalled by out_ready.
module os_array_ctrl #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int KW      = 10,
    parameter int MAC_LAT = os_array_pkg::MAC_LAT
) (
    input logic             clk,
    input logic             rst,
    os_array_ctrl_if.master bus
);
    import os_array_pkg::*;
    localparam int TW = t_width(KW, ROWS, COLS, MAC_LAT);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t        state, state_nx;
    logic [KW-1:0] k_reg;
    logic [TW-1:0] t, t_end;
    logic [RW-1:0] row;
    logic          done_q, beat, last;

    assign t_end = TW'(k_reg) + TW'(ROWS + COLS - 2 + MAC_LAT);
    assign beat  = (state == DRAIN) && bus.out_ready;
    assign last  = row == RW'(ROWS - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // t restarts at 0 on entry to COMPUTE; row is left at 0 after each drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg  <= '0;
            t      <= '0;
            row    <= '0;
            done_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) k_reg <= bus.k_len;
            t      <= (state == COMPUTE) ? t + TW'(1) : '0;
            row    <= beat ? (last ? '0 : row + RW'(1)) : row;
            done_q <= beat && last;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CLEAR;
            CLEAR:   state_nx = (k_reg == '0) ? DRAIN : COMPUTE;
            COMPUTE: if (t == t_end - TW'(1)) state_nx = DRAIN;
            DRAIN:   if (beat && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = state != IDLE;
        bus.done      = done_q;
        bus.acc_clr   = state == CLEAR;
        bus.rd_en     = (state == COMPUTE) && (t < TW'(k_reg));
        bus.rd_addr   = ((state == COMPUTE) && (t < TW'(k_reg))) ? t[KW-1:0] : '0;
        bus.drain_row = row;
        bus.out_valid = state == DRAIN;
        bus.out_last  = (state == DRAIN) && last;
    end

    os_skew_mask #(.N(ROWS), .KW(KW), .TW(TW)) a_mask (
        .en(state == COMPUTE), .t(t), .k(k_reg), .live(bus.a_live)
    );
    os_skew_mask #(.N(COLS), .KW(KW), .TW(TW)) b_mask (
        .en(state == COMPUTE), .t(t), .k(k_reg), .live(bus.b_live)
    );

`ifdef OS_ARRAY_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge clk) begin
        if (rst)                                  stall_cnt <= '0;
        else if (state == IDLE && bus.start)      stall_cnt <= '0;
        else if (state == DRAIN && !bus.out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
    end
    assign bus.stall_cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_os_array_ctrl.sv
// tb_os_array_ctrl: directed bench for os_array_ctrl with a behavioural 4x4 output-stationary array.
module tb_os_array_ctrl;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    os_array_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) bus ();
    os_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .MAC_LAT(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    logic signed [7:0] a_mem [1024][ROWS];
    logic signed [7:0] b_mem [1024][COLS];
    logic signed [7:0] sa [ROWS][ROWS];
    logic signed [7:0] sb [COLS][COLS];
    logic signed [7:0] ar [ROWS][COLS];
    logic signed [7:0] br [ROWS][COLS];
    int acc  [ROWS][COLS];
    int gold [ROWS][COLS];

    // Array model: buffer read (1 cycle), lane skew, PE operand regs shifting right/down, accumulate.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    sa[i][j] <= 8'sd0; sb[i][j] <= 8'sd0;
                    ar[i][j] <= 8'sd0; br[i][j] <= 8'sd0; acc[i][j] <= 0;
                end
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                sa[i][0] <= bus.rd_en ? a_mem[bus.rd_addr][i] : 8'sd0;
                for (int d = 1; d < ROWS; d++) sa[i][d] <= sa[i][d-1];
                ar[i][0] <= bus.a_live[i] ? sa[i][i] : 8'sd0;
                for (int j = 1; j < COLS; j++) ar[i][j] <= ar[i][j-1];
            end
            for (int j = 0; j < COLS; j++) begin
                sb[j][0] <= bus.rd_en ? b_mem[bus.rd_addr][j] : 8'sd0;
                for (int d = 1; d < COLS; d++) sb[j][d] <= sb[j][d-1];
                br[0][j] <= bus.b_live[j] ? sb[j][j] : 8'sd0;
                for (int i = 1; i < ROWS; i++) br[i][j] <= br[i-1][j];
            end
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    acc[i][j] <= bus.acc_clr ? 0 : acc[i][j] + int'(ar[i][j]) * int'(br[i][j]);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] all_outs();
        return {bus.busy, bus.done, bus.acc_clr, bus.rd_en, bus.rd_addr, bus.a_live,
                bus.b_live, bus.drain_row, bus.out_valid, bus.out_last};
    endfunction

    function automatic logic [127:0] acc_row(input int r);
        return {acc[r][3], acc[r][2], acc[r][1], acc[r][0]};
    endfunction

    function automatic logic [127:0] gold_row(input int r);
        return {gold[r][3], gold[r][2], gold[r][1], gold[r][0]};
    endfunction

    task automatic make_gold(input int k);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                gold[i][j] = 0;
                for (int kk = 0; kk < k; kk++) gold[i][j] += int'(a_mem[kk][i]) * int'(b_mem[kk][j]);
            end
    endtask

    // Entered while observing the CLEAR cycle; returns once the first drain cycle is observed.
    task automatic run_compute(input int k, input bit poke, output int ncyc, output int nrd,
                               output int maxa, output int a3f, output int a3l, output int err);
        ncyc = -1; nrd = 0; maxa = 0; a3f = -1; a3l = -1; err = 0;
        for (int c = 0; c < 1100; c++) begin
            step();
            if (bus.out_valid) begin
                ncyc = c;
                break;
            end
            bus.start = poke && (c == 3);
            if (poke && c == 3) bus.k_len = 10'd9;
            if (bus.rd_en) begin
                nrd++;
                if (int'(bus.rd_addr) > maxa) maxa = int'(bus.rd_addr);
            end
            if (bus.a_live[3]) begin
                if (a3f < 0) a3f = c;
                a3l = c;
            end
            if (bus.rd_en !== (c < k) || int'(bus.rd_addr) != ((c < k) ? c : 0) || !bus.busy || bus.acc_clr)
                err++;
            for (int i = 0; i < ROWS; i++)
                if (bus.a_live[i] !== (c >= i + 1 && c < i + 1 + k)) err++;
            for (int j = 0; j < COLS; j++)
                if (bus.b_live[j] !== (c >= j + 1 && c < j + 1 + k)) err++;
        end
        bus.start = 1'b0;
    endtask

    // Entered on the first drain cycle; leaves while observing the done cycle.
    task automatic run_drain(input int stall_row);
        int herr = 0;
        for (int r = 0; r < ROWS; r++) begin
            chk($sformatf("drain_row%0d", r), 128'(bus.drain_row), 128'(r));
            chk($sformatf("valid_last_done%0d", r), {bus.out_valid, bus.out_last, bus.done},
                {1'b1, 1'(r == ROWS - 1), 1'b0});
            chk($sformatf("result_row%0d", r), acc_row(r), gold_row(r));
            if (r == stall_row) begin
                for (int s = 0; s < 3; s++) begin
                    bus.out_ready = 1'b0;
                    step();
                    if (int'(bus.drain_row) != r || !bus.out_valid || bus.done) herr++;
                end
                bus.out_ready = 1'b1;
                chk("stall_hold", 128'(herr), 128'(0));
            end
            step();
        end
        chk("done_pulse", {bus.done, bus.busy, bus.out_valid}, 3'b100);
    endtask

    int ncyc, nrd, maxa, a3f, a3l, err;

    initial begin
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.out_ready = 1'b1;
        for (int kk = 0; kk < 1024; kk++) begin
            for (int i = 0; i < ROWS; i++) a_mem[kk][i] = 8'(kk * 37 + i * 11 + 5);
            for (int j = 0; j < COLS; j++) b_mem[kk][j] = 8'(kk * 23 - j * 19 + 100);
        end
        step();
        step();
        chk("reset_outs", all_outs(), '0);
        rst = 1'b0;
        step();
        chk("idle_outs", all_outs(), '0);

        // k=8 tile, no backpressure
        make_gold(8);
        bus.k_len = 10'd8; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("k8_clear", {bus.acc_clr, bus.busy, bus.rd_en, bus.out_valid}, 4'b1100);
        run_compute(8, 1'b0, ncyc, nrd, maxa, a3f, a3l, err);
        chk("k8_compute_len", 128'(ncyc), 128'(16));
        chk("k8_rd_cnt", 128'(nrd), 128'(8));
        chk("k8_a3_window", {32'(a3f), 32'(a3l)}, {32'd4, 32'd11});
        chk("k8_max_addr", 128'(maxa), 128'(7));
        chk("k8_lane_err", 128'(err), 128'(0));
        run_drain(-1);

        // start in the done cycle -> back-to-back k=3 tile; start during COMPUTE ignored; stall row 1
        make_gold(3);
        bus.k_len = 10'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("b2b_clear", {bus.acc_clr, bus.busy, bus.rd_en, bus.out_valid}, 4'b1100);
        run_compute(3, 1'b1, ncyc, nrd, maxa, a3f, a3l, err);
        chk("k3_compute_len", 128'(ncyc), 128'(11));
        chk("k3_rd_cnt", 128'(nrd), 128'(3));
        chk("k3_lane_err", 128'(err), 128'(0));
        run_drain(1);
`ifdef OS_ARRAY_CTRL_PERF_EN
        chk("stall_cnt", 128'(bus.stall_cnt), 128'(3));
`endif
        step();
        chk("idle_after_b2b", all_outs(), '0);

        // k=0: CLEAR straight to DRAIN, zero results
        make_gold(0);
        bus.k_len = 10'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("k0_clear", {bus.acc_clr, bus.busy, bus.rd_en, bus.out_valid}, 4'b1100);
`ifdef OS_ARRAY_CTRL_PERF_EN
        chk("stall_cnt_clr", 128'(bus.stall_cnt), 128'(0));
`endif
        run_compute(0, 1'b0, ncyc, nrd, maxa, a3f, a3l, err);
        chk("k0_compute_len", 128'(ncyc), 128'(0));
        chk("k0_rd_cnt", 128'(nrd), 128'(0));
        run_drain(-1);

        // reset during COMPUTE at t=5
        bus.k_len = 10'd8; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int s = 0; s < 6; s++) step();
        chk("t5_addr", {bus.rd_en, bus.rd_addr}, {1'b1, 10'd5});
        rst = 1'b1;
        step();
        chk("rst_abort", all_outs(), '0);
        rst = 1'b0;
        step();
        chk("rst_no_done", all_outs(), '0);

        // fresh k=1 tile
        make_gold(1);
        bus.k_len = 10'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("k1_clear", {bus.acc_clr, bus.busy, bus.rd_en, bus.out_valid}, 4'b1100);
        run_compute(1, 1'b0, ncyc, nrd, maxa, a3f, a3l, err);
        chk("k1_compute_len", 128'(ncyc), 128'(9));
        chk("k1_rd_cnt", 128'(nrd), 128'(1));
        chk("k1_lane_err", 128'(err), 128'(0));
        run_drain(-1);

        // maximum depth
        make_gold(1023);
        bus.k_len = 10'd1023; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("kmax_clear", {bus.acc_clr, bus.busy, bus.rd_en, bus.out_valid}, 4'b1100);
        run_compute(1023, 1'b0, ncyc, nrd, maxa, a3f, a3l, err);
        chk("kmax_compute_len", 128'(ncyc), 128'(1031));
        chk("kmax_rd_cnt", 128'(nrd), 128'(1023));
        chk("kmax_max_addr", 128'(maxa), 128'(1022));
        chk("kmax_lane_err", 128'(err), 128'(0));
        run_drain(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
